inst_packer: RTL and testbench

INST_PACKER -- requirements
Module: inst_packer

---
 rtl/inst_pkg.sv | 31 +++
 rtl/imm_pack.sv | 44 ++++
 rtl/inst_packer.sv | 106 ++++++++++
 tb/tb_inst_packer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_pkg.sv
// Shared encodings for the instruction packer: opcodes, request formats,
// packer FSM states and the register/function field bundle.
package inst_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;

    typedef enum logic [1:0] {
        FMT_BRANCH = 2'b00,
        FMT_LOAD   = 2'b01,
        FMT_STORE  = 2'b10,
        FMT_OPIMM  = 2'b11
    } fmt_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_WRITE = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
    } fields_t;

endpackage

// File: rtl/imm_pack.sv
// Combinational instruction word builder plus immediate range check.
module imm_pack
    import inst_pkg::*;
(
    input  fmt_e        fmt,
    input  fields_t     fields,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        range_err
);

    logic w_i_ok;
    logic w_b_ok;

    // 12-bit signed for I/S types; 13-bit signed, even, for branches
    assign w_i_ok = (&imm[31:11]) | ~(|imm[31:11]);
    assign w_b_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];

    always_comb begin
        word      = '0;
        range_err = 1'b0;
        case (fmt)
            FMT_BRANCH: begin
                word = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                        imm[4:1], imm[11], OP_BRANCH};
                range_err = ~w_b_ok;
            end
            FMT_LOAD: begin
                word = {imm[11:0], fields.rs1, fields.funct3, fields.rd, OP_LOAD};
                range_err = ~w_i_ok;
            end
            FMT_STORE: begin
                word = {imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                        imm[4:0], OP_STORE};
                range_err = ~w_i_ok;
            end
            FMT_OPIMM: begin
                word = {imm[11:0], fields.rs1, fields.funct3, fields.rd, OP_OPIMM};
                range_err = ~w_i_ok;
            end
        endcase
    end

endmodule

// File: rtl/inst_packer.sv
// Accepts instruction requests, packs them into 32-bit words and writes them
// to sequential instruction-memory addresses; bad immediates are counted and dropped.
module inst_packer
    import inst_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_fmt,
    input  logic [4:0]       req_rd,
    input  logic [4:0]       req_rs1,
    input  logic [4:0]       req_rs2,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_imm,
    input  logic             req_last,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ack,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] err_cnt
);

    state_e           r_state;
    state_e           w_next;
    logic [31:0]      r_addr;
    logic [31:0]      r_word;
    logic             r_last;
    logic [ERR_W-1:0] r_err_cnt;

    fields_t          w_fields;
    logic [31:0]      w_word;
    logic             w_range_err;
    logic             w_accept;
    logic             w_start_ok;

    assign w_fields   = {req_rd, req_rs1, req_rs2, req_funct3};
    assign w_accept   = (r_state == S_ARMED) && req_valid;
    assign w_start_ok = (r_state == S_IDLE) && start;

    imm_pack u_imm_pack (
        .fmt       (fmt_e'(req_fmt)),
        .fields    (w_fields),
        .imm       (req_imm),
        .word      (w_word),
        .range_err (w_range_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_ARMED;
            S_ARMED: begin
                if (req_valid) begin
                    if (w_range_err) w_next = req_last ? S_DONE : S_ARMED;
                    else             w_next = S_WRITE;
                end
            end
            S_WRITE: if (mem_ack) w_next = r_last ? S_DONE : S_ARMED;
            S_DONE:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_word    <= '0;
            r_last    <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_start_ok) begin
                r_addr    <= base_addr & 32'hFFFF_FFFC;
                r_err_cnt <= '0;
            end
            if (w_accept) begin
                r_word <= w_word;
                r_last <= req_last;
                if (w_range_err && !(&r_err_cnt))
                    r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
            if ((r_state == S_WRITE) && mem_ack)
                r_addr <= r_addr + 32'd4;
        end
    end

    // Write strobe comes straight from the state register, so reset kills it at once
    assign req_ready = (r_state == S_ARMED);
    assign mem_we    = (r_state == S_WRITE);
    assign busy      = (r_state == S_ARMED) || (r_state == S_WRITE);
    assign done      = (r_state == S_DONE);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_word;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_inst_packer.sv
// Directed bench for inst_packer: memory responder with programmable ack delay,
// write log, and hand-computed expected words and addresses.
`timescale 1ns/1ps
module tb_inst_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_fmt;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [2:0]  req_funct3;
    logic [31:0] req_imm;
    logic        req_last;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        busy;
    logic        done;
    logic [7:0]  err_cnt;

    int n_chk = 0;
    int n_err = 0;
    int ack_dly = 0;
    int we_cyc = 0;
    int wr_n = 0;
    int done_cnt = 0;
    logic [31:0] wr_addr [16];
    logic [31:0] wr_data [16];

    always #5 clk = ~clk;

    inst_packer #(.ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .req_valid(req_valid), .req_ready(req_ready), .req_fmt(req_fmt),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_funct3(req_funct3), .req_imm(req_imm), .req_last(req_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .busy(busy), .done(done), .err_cnt(err_cnt)
    );

    // Memory responder: ack after ack_dly cycles of mem_we; log the write it completes
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mem_we) begin
            mem_ack = (we_cyc >= ack_dly);
            we_cyc++;
            if (mem_ack && wr_n < 16) begin
                wr_addr[wr_n] = mem_addr;
                wr_data[wr_n] = mem_wdata;
                wr_n++;
            end
        end else begin
            mem_ack = 1'b0;
            we_cyc  = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [1:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
                        input logic last);
        int t;
        @(negedge clk);
        req_fmt = fmt; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
        req_funct3 = f3; req_imm = imm; req_last = last;
        req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("send_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_wr(input int n);
        int t;
        t = 0;
        while (wr_n < n && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("wr_count", 32'(wr_n), 32'(n));
    endtask

    task automatic wait_done(input int n);
        int t;
        t = 0;
        while (done_cnt < n && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", 32'(done_cnt), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; req_valid = 1'b0;
        req_fmt = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
        req_funct3 = '0; req_imm = '0; req_last = 1'b0; mem_ack = 1'b0;
        #13;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_we",    32'(mem_we),    32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_addr",  mem_addr,       32'h0);
        chk("rst_wdata", mem_wdata,      32'h0);
        chk("rst_err",   32'(err_cnt),   32'd0);
        @(negedge clk) rst_n = 1'b1;

        // op-imm x1 = x0 + 5 at base 0x100
        do_start(32'h100);
        chk("t1_ready", 32'(req_ready), 32'd1);
        chk("t1_busy",  32'(busy),      32'd1);
        chk("t1_base",  mem_addr,       32'h100);
        send(2'b11, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1'b1);
        wait_wr(1);
        chk("t1_addr", wr_addr[0], 32'h100);
        chk("t1_data", wr_data[0], 32'h0050_0093);
        wait_done(1);
        repeat (3) @(negedge clk);
        chk("t1_done_once", 32'(done_cnt), 32'd1);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // branch -8 then store with last
        do_start(32'h100);
        send(2'b00, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFF8, 1'b0);
        send(2'b10, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8, 1'b1);
        wait_wr(3);
        chk("t2_br_addr", wr_addr[1], 32'h100);
        chk("t2_br_data", wr_data[1], 32'hFE20_8CE3);
        chk("t2_st_addr", wr_addr[2], 32'h104);
        chk("t2_st_data", wr_data[2], 32'h0020_A423);
        wait_done(2);
        repeat (3) @(negedge clk);
        chk("t2_done_once", 32'(done_cnt), 32'd2);
        chk("t2_addr_end", mem_addr, 32'h108);

        // load with a 3-cycle ack delay: write held for 4 cycles
        do_start(32'h200);
        ack_dly = 3;
        send(2'b01, 5'd3, 5'd2, 5'd0, 3'd2, 32'hFFFF_FFFC, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_we_held", 32'(mem_we), 32'd1);
            chk("t3_wdata",   mem_wdata,   32'hFFC1_2183);
            chk("t3_addr",    mem_addr,    32'h200);
        end
        @(negedge clk);
        chk("t3_we_drop", 32'(mem_we), 32'd0);
        wait_done(3);
        repeat (2) @(negedge clk);
        chk("t3_one_write", 32'(wr_n), 32'd4);
        ack_dly = 0;

        // two bad immediates then one good op-imm
        do_start(32'h300);
        send(2'b11, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 1'b0);
        chk("t4_err1", 32'(err_cnt), 32'd1);
        chk("t4_no_we", 32'(mem_we), 32'd0);
        send(2'b00, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3, 1'b0);
        send(2'b11, 5'd4, 5'd0, 5'd0, 3'd0, 32'd7, 1'b1);
        wait_done(4);
        repeat (2) @(negedge clk);
        chk("t4_err2",   32'(err_cnt), 32'd2);
        chk("t4_writes", 32'(wr_n),    32'd5);
        chk("t4_addr",   wr_addr[4],   32'h300);
        chk("t4_data",   wr_data[4],   32'h0070_0213);

        // reset in the middle of a write
        do_start(32'h400);
        chk("t5_err_clr", 32'(err_cnt), 32'd0);
        ack_dly = 20;
        send(2'b11, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1'b1);
        @(negedge clk);
        chk("t5_we_up", 32'(mem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_we_async", 32'(mem_we),    32'd0);
        chk("t5_busy",     32'(busy),      32'd0);
        chk("t5_ready",    32'(req_ready), 32'd0);
        chk("t5_addr",     mem_addr,       32'h0);
        @(negedge clk) rst_n = 1'b1;
        ack_dly = 0;
        chk("t5_no_write", 32'(wr_n), 32'd5);
        do_start(32'h500);
        chk("t5_restart", 32'(busy), 32'd1);
        send(2'b11, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1'b1);
        wait_wr(6);
        chk("t5_addr2", wr_addr[5], 32'h500);
        wait_done(5);

        // start while busy and req_valid while idle are both ignored
        do_start(32'h600);
        do_start(32'h700);
        chk("t6_addr_kept", mem_addr,       32'h600);
        chk("t6_busy",      32'(busy),      32'd1);
        chk("t6_ready",     32'(req_ready), 32'd1);
        send(2'b11, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1'b1);
        wait_wr(7);
        chk("t6_wr_addr", wr_addr[6], 32'h600);
        wait_done(6);
        repeat (2) @(negedge clk);
        req_fmt = 2'b11; req_imm = 32'd1; req_last = 1'b1;
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_idle_ready", 32'(req_ready), 32'd0);
        chk("t6_idle_busy",  32'(busy),      32'd0);
        chk("t6_idle_addr",  mem_addr,       32'h604);
        chk("t6_idle_wr",    32'(wr_n),      32'd7);
        req_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
